// File: rtl/cmp_stat_pkg.sv
// Shared types and constants for the comparator statistics tracker.
package cmp_stat_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    localparam int DEF_WINDOW = 16;
    localparam int DEF_CNT_W  = 8;
    localparam int OPND_W     = 4;

    function automatic logic is_onehot3(input logic [2:0] flags);
        return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    endfunction

endpackage

// File: rtl/cmp_stat_tracker_if.sv
// Sample and report handshake bundle between a comparator stream and the tracker.
interface cmp_stat_tracker_if
    import cmp_stat_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic              in_valid;
    logic              in_ready;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic              a_greater_b;
    logic              a_equal_b;
    logic              a_less_b;
    logic              rpt_valid;
    logic              rpt_ready;
    logic [CNT_W-1:0]  rpt_gt_cnt;
    logic [CNT_W-1:0]  rpt_eq_cnt;
    logic [CNT_W-1:0]  rpt_lt_cnt;
    logic [OPND_W-1:0] rpt_max;
    logic [OPND_W-1:0] rpt_min;
    logic              flag_err;

    modport master (
        output in_valid, a, b, a_greater_b, a_equal_b, a_less_b, rpt_ready,
        input  in_ready, rpt_valid, rpt_gt_cnt, rpt_eq_cnt, rpt_lt_cnt,
               rpt_max, rpt_min, flag_err
    );

    modport slave (
        input  in_valid, a, b, a_greater_b, a_equal_b, a_less_b, rpt_ready,
        output in_ready, rpt_valid, rpt_gt_cnt, rpt_eq_cnt, rpt_lt_cnt,
               rpt_max, rpt_min, flag_err
    );

endinterface

// File: rtl/cmp_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module cmp_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cmp_stat_tracker.sv
// Collects per-window class counts and operand extremes from a comparator stream.
// Optional one-hot flag checking is enabled by defining CMP_STAT_ONEHOT_CHECK_EN.
module cmp_stat_tracker
    import cmp_stat_pkg::*;
#(
    parameter int WINDOW = DEF_WINDOW,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    cmp_stat_tracker_if.slave bus
);

    localparam int SC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [SC_W-1:0] LAST_IDX = SC_W'(WINDOW - 1);

    state_t            state;
    logic              rpt_valid_r;
    logic [SC_W-1:0]   sample_cnt;
    logic [OPND_W-1:0] run_max;
    logic [OPND_W-1:0] run_min;
    logic [OPND_W-1:0] larger;
    logic [OPND_W-1:0] smaller;
    logic              in_ready;
    logic              accept;
    logic              rpt_done;
    logic              sample_ok;
    logic              cls_gt;
    logic              cls_eq;
    logic              cls_lt;

    assign in_ready = (state == ACCUM) && !rst;
    assign accept   = bus.in_valid && in_ready;
    assign rpt_done = rpt_valid_r && bus.rpt_ready;

`ifdef CMP_STAT_ONEHOT_CHECK_EN
    logic err;

    assign sample_ok = is_onehot3({bus.a_greater_b, bus.a_equal_b, bus.a_less_b});

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && !sample_ok) begin
            err <= 1'b1;
        end
    end

    assign bus.flag_err = err;
`else
    assign sample_ok    = 1'b1;
    assign bus.flag_err = 1'b0;
`endif

    // Priority classification: GT wins over EQ, EQ over LT.
    assign cls_gt  = bus.a_greater_b;
    assign cls_eq  = !bus.a_greater_b && bus.a_equal_b;
    assign cls_lt  = !bus.a_greater_b && !bus.a_equal_b;
    assign larger  = bus.a_greater_b ? bus.a : bus.b;
    assign smaller = bus.a_less_b    ? bus.a : bus.b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACCUM;
            rpt_valid_r <= 1'b0;
            sample_cnt  <= '0;
            run_max     <= '0;
            run_min     <= '1;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (sample_ok && (larger > run_max)) begin
                            run_max <= larger;
                        end
                        if (sample_ok && (smaller < run_min)) begin
                            run_min <= smaller;
                        end
                        if (sample_cnt == LAST_IDX) begin
                            sample_cnt  <= '0;
                            state       <= REPORT;
                            rpt_valid_r <= 1'b1;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                REPORT: begin
                    if (bus.rpt_ready) begin
                        state       <= ACCUM;
                        rpt_valid_r <= 1'b0;
                        sample_cnt  <= '0;
                        run_max     <= '0;
                        run_min     <= '1;
                    end
                end
                default: begin
                    state       <= ACCUM;
                    rpt_valid_r <= 1'b0;
                end
            endcase
        end
    end

    cmp_sat_counter #(.WIDTH(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (rpt_done),
        .inc   (accept && sample_ok && cls_gt),
        .count (bus.rpt_gt_cnt)
    );

    cmp_sat_counter #(.WIDTH(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (rpt_done),
        .inc   (accept && sample_ok && cls_eq),
        .count (bus.rpt_eq_cnt)
    );

    cmp_sat_counter #(.WIDTH(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (rpt_done),
        .inc   (accept && sample_ok && cls_lt),
        .count (bus.rpt_lt_cnt)
    );

    assign bus.in_ready  = in_ready;
    assign bus.rpt_valid = rpt_valid_r;
    assign bus.rpt_max   = run_max;
    assign bus.rpt_min   = run_min;

endmodule

// File: tb/tb_cmp_stat_tracker.sv
// Bench for cmp_stat_tracker: two instances (WINDOW=4/CNT_W=8 and WINDOW=6/CNT_W=2) share stimulus.
// Honours CMP_STAT_ONEHOT_CHECK_EN the same way the design does.
module tb_cmp_stat_tracker;

`ifdef CMP_STAT_ONEHOT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int gt;
        int eq;
        int lt;
        int mx;
        int mn;
    } stats_t;

    logic clk;
    logic rst;

    cmp_stat_tracker_if #(.CNT_W(8)) bus_a ();
    cmp_stat_tracker_if #(.CNT_W(2)) bus_b ();

    cmp_stat_tracker #(.WINDOW(4), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    cmp_stat_tracker #(.WINDOW(6), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: the accepted samples of the current window, whether a report is pending, sticky error.
    logic [10:0] q_a[$];
    logic [10:0] q_b[$];
    bit rep_a, rep_b, err_a, err_b;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [2:0] flags_of(input logic [3:0] x, input logic [3:0] y);
        return {x > y, x == y, x < y};
    endfunction

    // Window statistics straight from the list of accepted samples.
    function automatic stats_t compute(input logic [10:0] q[$], input int cnt_w);
        stats_t s;
        int cap, lg, sm, av, bv;
        logic [2:0] f;
        s.gt = 0; s.eq = 0; s.lt = 0; s.mx = 0; s.mn = 15;
        cap = (1 << cnt_w) - 1;
        foreach (q[i]) begin
            av = int'(q[i][10:7]);
            bv = int'(q[i][6:3]);
            f  = q[i][2:0];
            if (CHK && ($countones(f) != 1)) continue;
            if (f[2]) s.gt++;
            else if (f[1]) s.eq++;
            else s.lt++;
            lg = f[2] ? av : bv;
            sm = f[0] ? av : bv;
            if (lg > s.mx) s.mx = lg;
            if (sm < s.mn) s.mn = sm;
        end
        if (s.gt > cap) s.gt = cap;
        if (s.eq > cap) s.eq = cap;
        if (s.lt > cap) s.lt = cap;
        return s;
    endfunction

    // Drive one cycle of inputs, check both DUTs against the model, then advance the model across the edge.
    task automatic applyStimulus(input bit r, input bit v, input logic [3:0] aa, input logic [3:0] bb,
                                 input logic [2:0] f, input bit rr);
        stats_t sa, sb;
        rst = r;
        bus_a.in_valid = v; bus_a.a = aa; bus_a.b = bb; bus_a.rpt_ready = rr;
        {bus_a.a_greater_b, bus_a.a_equal_b, bus_a.a_less_b} = f;
        bus_b.in_valid = v; bus_b.a = aa; bus_b.b = bb; bus_b.rpt_ready = rr;
        {bus_b.a_greater_b, bus_b.a_equal_b, bus_b.a_less_b} = f;
        #1;
        sa = compute(q_a, 8);
        sb = compute(q_b, 2);
        checkOutput("a.in_ready",  32'(bus_a.in_ready),   32'(!r && !rep_a));
        checkOutput("a.rpt_valid", 32'(bus_a.rpt_valid),  32'(rep_a));
        checkOutput("a.gt",        32'(bus_a.rpt_gt_cnt), 32'(sa.gt));
        checkOutput("a.eq",        32'(bus_a.rpt_eq_cnt), 32'(sa.eq));
        checkOutput("a.lt",        32'(bus_a.rpt_lt_cnt), 32'(sa.lt));
        checkOutput("a.max",       32'(bus_a.rpt_max),    32'(sa.mx));
        checkOutput("a.min",       32'(bus_a.rpt_min),    32'(sa.mn));
        checkOutput("a.flag_err",  32'(bus_a.flag_err),   32'(err_a));
        checkOutput("b.in_ready",  32'(bus_b.in_ready),   32'(!r && !rep_b));
        checkOutput("b.rpt_valid", 32'(bus_b.rpt_valid),  32'(rep_b));
        checkOutput("b.gt",        32'(bus_b.rpt_gt_cnt), 32'(sb.gt));
        checkOutput("b.eq",        32'(bus_b.rpt_eq_cnt), 32'(sb.eq));
        checkOutput("b.lt",        32'(bus_b.rpt_lt_cnt), 32'(sb.lt));
        checkOutput("b.max",       32'(bus_b.rpt_max),    32'(sb.mx));
        checkOutput("b.min",       32'(bus_b.rpt_min),    32'(sb.mn));
        checkOutput("b.flag_err",  32'(bus_b.flag_err),   32'(err_b));
        @(posedge clk);
        if (r) begin
            q_a.delete(); rep_a = 0; err_a = 0;
            q_b.delete(); rep_b = 0; err_b = 0;
        end else begin
            if (rep_a) begin
                if (rr) begin rep_a = 0; q_a.delete(); end
            end else if (v) begin
                q_a.push_back({aa, bb, f});
                if (CHK && ($countones(f) != 1)) err_a = 1;
                if (q_a.size() == 4) rep_a = 1;
            end
            if (rep_b) begin
                if (rr) begin rep_b = 0; q_b.delete(); end
            end else if (v) begin
                q_b.push_back({aa, bb, f});
                if (CHK && ($countones(f) != 1)) err_b = 1;
                if (q_b.size() == 6) rep_b = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic sendSample(input logic [3:0] aa, input logic [3:0] bb, input bit rr);
        applyStimulus(1'b0, 1'b1, aa, bb, flags_of(aa, bb), rr);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 3'b010, 1'b0);
    endtask

    initial begin
        bit r, v, rr;
        logic [3:0] aa, bb;
        logic [2:0] f;

        rst = 1'b1;
        bus_a.in_valid = 0; bus_a.a = 0; bus_a.b = 0; bus_a.rpt_ready = 0;
        {bus_a.a_greater_b, bus_a.a_equal_b, bus_a.a_less_b} = 3'b000;
        bus_b.in_valid = 0; bus_b.a = 0; bus_b.b = 0; bus_b.rpt_ready = 0;
        {bus_b.a_greater_b, bus_b.a_equal_b, bus_b.a_less_b} = 3'b000;
        rep_a = 0; rep_b = 0; err_a = 0; err_b = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, window of four mixed samples
        doReset();
        sendSample(4'd11, 4'd9, 1'b0);
        sendSample(4'd3,  4'd3, 1'b0);
        sendSample(4'd2,  4'd7, 1'b0);
        sendSample(4'd15, 4'd0, 1'b0);
        checkOutput("w4.rpt_valid", 32'(bus_a.rpt_valid),  32'd1);
        checkOutput("w4.gt",        32'(bus_a.rpt_gt_cnt), 32'd2);
        checkOutput("w4.eq",        32'(bus_a.rpt_eq_cnt), 32'd1);
        checkOutput("w4.lt",        32'(bus_a.rpt_lt_cnt), 32'd1);
        checkOutput("w4.max",       32'(bus_a.rpt_max),    32'd15);
        checkOutput("w4.min",       32'(bus_a.rpt_min),    32'd0);

        // Report held under back-pressure while samples are offered
        repeat (5) sendSample(4'd1, 4'd14, 1'b0);
        checkOutput("hold.gt",  32'(bus_a.rpt_gt_cnt), 32'd2);
        checkOutput("hold.min", 32'(bus_a.rpt_min),    32'd0);
        // Sample coinciding with report acceptance is refused, then taken next cycle
        sendSample(4'd6, 4'd2, 1'b1);
        checkOutput("clr.in_ready", 32'(bus_a.in_ready),   32'd1);
        checkOutput("clr.gt",       32'(bus_a.rpt_gt_cnt), 32'd0);
        checkOutput("clr.max",      32'(bus_a.rpt_max),    32'd0);
        checkOutput("clr.min",      32'(bus_a.rpt_min),    32'd15);
        sendSample(4'd6, 4'd2, 1'b0);
        checkOutput("new.gt",  32'(bus_a.rpt_gt_cnt), 32'd1);
        checkOutput("new.max", 32'(bus_a.rpt_max),    32'd6);

        // Saturation of the 2-bit counters
        doReset();
        repeat (6) sendSample(4'd9, 4'd4, 1'b0);
        checkOutput("sat.rpt_valid", 32'(bus_b.rpt_valid),  32'd1);
        checkOutput("sat.gt",        32'(bus_b.rpt_gt_cnt), 32'd3);
        checkOutput("sat.eq",        32'(bus_b.rpt_eq_cnt), 32'd0);
        checkOutput("sat.lt",        32'(bus_b.rpt_lt_cnt), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 3'b000, 1'b1);

        // Reset mid-window discards the partial data
        doReset();
        sendSample(4'd7, 4'd1, 1'b0);
        sendSample(4'd7, 4'd1, 1'b0);
        doReset();
        repeat (4) sendSample(4'd5, 4'd5, 1'b0);
        checkOutput("rstmid.rpt_valid", 32'(bus_a.rpt_valid),  32'd1);
        checkOutput("rstmid.eq",        32'(bus_a.rpt_eq_cnt), 32'd4);
        checkOutput("rstmid.gt",        32'(bus_a.rpt_gt_cnt), 32'd0);
        checkOutput("rstmid.max",       32'(bus_a.rpt_max),    32'd5);
        checkOutput("rstmid.min",       32'(bus_a.rpt_min),    32'd5);
        checkOutput("rstmid.b_eq",      32'(bus_b.rpt_eq_cnt), 32'd3);

        // Illegal flag combination
        doReset();
        applyStimulus(1'b0, 1'b1, 4'd9, 4'd4, 3'b110, 1'b0);
        checkOutput("bad.flag_err", 32'(bus_a.flag_err),   CHK ? 32'd1 : 32'd0);
        checkOutput("bad.gt",       32'(bus_a.rpt_gt_cnt), CHK ? 32'd0 : 32'd1);
        checkOutput("bad.eq",       32'(bus_a.rpt_eq_cnt), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            v  = ($urandom_range(0, 99) < 70);
            rr = ($urandom_range(0, 99) < 40);
            aa = 4'($urandom_range(0, 15));
            bb = 4'($urandom_range(0, 15));
            f  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : flags_of(aa, bb);
            applyStimulus(r, v, aa, bb, f, rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cmp_stat_tracker.md
CMP_STAT_TRACKER -- requirements
Module: cmp_stat_tracker

Interface
REQ-001 SHALL have parameter WINDOW, default 16: accepted samples per report; legal range >=1.
REQ-002 SHALL have parameter CNT_W, default 8: width of each class counter.
REQ-003 SHALL have port clk  in  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  in  1  a sample with its comparator flags is present.
REQ-006 SHALL have port in_ready  out  1  the tracker accepts the sample this cycle.
REQ-007 SHALL have ports a, b  in  4 each  operands that were fed to the upstream comparator.
REQ-008 SHALL have ports a_greater_b, a_equal_b, a_less_b  in  1 each  comparator result flags.
REQ-009 SHALL have port rpt_valid  out  1  a window report is held on the report outputs.
REQ-010 SHALL have port rpt_ready  in  1  the consumer accepts the report.
REQ-011 SHALL have ports rpt_gt_cnt, rpt_eq_cnt, rpt_lt_cnt  out  CNT_W each  class counts for the window.
REQ-012 SHALL have ports rpt_max, rpt_min  out  4 each  largest and smallest operand seen in the window.
REQ-013 SHALL have port flag_err  out  1  sticky flag for an illegal flag combination.

Function
REQ-014 SHALL implement FSM states ACCUM and REPORT.
REQ-015 In ACCUM, in_ready SHALL be 1 and rpt_valid SHALL be 0.
  - A sample is accepted in any cycle where in_valid and in_ready are both 1.
REQ-016 On an accepted sample, the class SHALL be chosen as GT if a_greater_b, else EQ if a_equal_b, else LT.
  - The matching counter increments by 1.
REQ-017 Class counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 On an accepted sample, operands SHALL be ordered using the flags: larger = a_greater_b ? a : b; smaller = a_less_b ? a : b.
  - The running max is updated if larger exceeds it.
  - The running min is updated if smaller is below it.
REQ-019 The sample counter SHALL count accepted samples.
  - On the WINDOW-th accepted sample, the FSM goes to REPORT on the next cycle (1-cycle latency).
  - That last sample's contribution is included in the report.
REQ-020 In REPORT, rpt_valid SHALL be 1 and in_ready SHALL be 0.
  - Report outputs stay constant until rpt_ready is 1.
REQ-021 When rpt_valid and rpt_ready are both 1, the next cycle SHALL return to ACCUM with:
  - counters and sample counter at 0
  - running max at 4'h0
  - running min at 4'hF
REQ-022 An in_valid that coincides with report acceptance SHALL NOT be accepted (in_ready is 0 that cycle).
REQ-023 While in ACCUM, rpt_* data outputs SHALL show the live accumulators; they are valid only when rpt_valid is 1.

Reset
REQ-024 With rst=1 at a clock edge, the block SHALL go to ACCUM with:
  - all counters 0
  - max 4'h0, min 4'hF
  - flag_err 0, rpt_valid 0
REQ-025 in_ready SHALL be 0 in any cycle where rst is 1.
REQ-026 A reset mid-window or during REPORT SHALL discard all partial and pending data.

Configuration
REQ-027 Macro CMP_STAT_ONEHOT_CHECK_EN defined:
  - An accepted sample whose flags are not exactly one-hot sets flag_err on the next cycle.
  - flag_err stays set until rst.
  - That sample counts toward WINDOW but does not change the class counters, max or min.
REQ-028 Macro CMP_STAT_ONEHOT_CHECK_EN undefined:
  - No check is done, and the REQ-016 priority classifies every sample.
  - flag_err is tied to 0; the port is always present.

Structure
REQ-029 Package cmp_stat_pkg SHALL hold:
  - the state enum {ACCUM, REPORT}
  - default constants for WINDOW and CNT_W
  - the operand width constant (4)
REQ-030 The class counters SHALL be three instances of sub-module cmp_sat_counter (parameter width; inputs clr, inc; saturating).

Verification
REQ-031 With WINDOW=4, feed (11,9), (3,3), (2,7), (15,0) with correct flags -> the cycle after the 4th sample gives rpt_valid=1, gt=2, eq=1, lt=1, max=15, min=0.
REQ-032 Hold rpt_ready=0 for 5 cycles in REPORT with in_valid=1 -> outputs stable, in_ready=0, nothing accepted; then rpt_ready=1 -> next cycle ACCUM with counts 0, max 0, min 15.
REQ-033 With CNT_W=2, WINDOW=6, send six samples with a>b -> rpt_gt_cnt=3 (saturated), eq=0, lt=0.
REQ-034 With WINDOW=4, assert rst after 2 samples, then send 4 samples (5,5) -> a single report with eq=4, max=5, min=5.
REQ-035 Send flags 3'b110 on (9,4): macro defined -> flag_err=1 the next cycle, no class counted; macro undefined -> gt incremented, flag_err=0.
REQ-036 Assert in_valid in the cycle the report is accepted -> that sample is not accepted; it is accepted the following cycle and counts as sample 1 of the new window.
